// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter: N_REQ ready/valid streams into one registered
// output stage, grant held for a whole packet, beats tagged with source index.
module stream_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 32,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        in_valid,
  output logic [N_REQ-1:0]        in_ready,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  input  logic [N_REQ-1:0]        in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [SRC_W-1:0]        out_src
);

  logic [SRC_W-1:0]  rr_ptr;
  logic              lock;
  logic [SRC_W-1:0]  lock_id;

  logic [SRC_W-1:0]  grant;
  logic              has_grant;
  logic [SRC_W:0]    idx;
  logic              load_en;
  logic              go;
  logic              accept;
  logic [DATA_W-1:0] beat_data;
  logic              beat_last;
  logic [SRC_W-1:0]  next_ptr;

  // Search starts at rr_ptr and wraps; idx is one bit wider so the wrap
  // subtract works for any N_REQ, not only powers of two.
  always_comb begin
    grant = '0;
    has_grant = 1'b0;
    idx = '0;
    if (lock) begin
      grant = lock_id;
      has_grant = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
        if (idx >= (SRC_W+1)'(N_REQ))
          idx = idx - (SRC_W+1)'(N_REQ);
        if (!has_grant && in_valid[idx[SRC_W-1:0]]) begin
          has_grant = 1'b1;
          grant = idx[SRC_W-1:0];
        end
      end
    end
  end

  assign load_en = !out_valid || out_ready;
  assign go = has_grant && load_en && !rst;
  assign in_ready = go ? (N_REQ'(1) << grant) : '0;
  assign accept = go && in_valid[grant];
  assign beat_data = in_data[int'(grant)*DATA_W +: DATA_W];
  assign beat_last = in_last[grant];
  assign next_ptr = (grant == SRC_W'(N_REQ-1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_src <= '0;
      rr_ptr <= '0;
      lock <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data <= beat_data;
      out_last <= beat_last;
      out_src <= grant;
      if (beat_last) begin
        lock <= 1'b0;
        rr_ptr <= next_ptr;
      end else begin
        lock <= 1'b1;
        lock_id <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed plan steps then random traffic,
// checked against a packet-level grant model and a beat scoreboard.
module tb_stream_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct packed {
    logic [1:0]   s;
    logic         l;
    logic [W-1:0] d;
  } sb_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;

  stream_rr_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .out_src(out_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = -1;

  int m_ptr = 0;
  int m_lid = 0;
  bit m_lock = 0;

  beat_t src_q[N][$];
  sb_t sb[$];
  logic [33:0] log_q[$];
  int logc[$];
  logic [N-1:0] en;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int mgrant(logic [N-1:0] v);
    if (m_lock) return m_lid;
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [33:0] lg(int k);
    if (k < log_q.size()) return log_q[k];
    return 'x;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i] = en[i];
        in_data[i*W +: W] = src_q[i][0].d;
        in_last[i] = src_q[i][0].l;
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*W +: W] = '0;
        in_last[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    int g;
    bit ld;
    logic [N-1:0] er;
    #1;
    g = rst ? -1 : mgrant(in_valid);
    ld = (sb.size() == 0) || out_ready;
    er = '0;
    if (g >= 0 && ld) er[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(sb[0].d));
      chk("out_last", 64'(out_last), 64'(sb[0].l));
      chk("out_src", 64'(out_src), 64'(sb[0].s));
    end
    acc = -1;
    if (rst) begin
      sb.delete();
      m_ptr = 0;
      m_lock = 0;
      m_lid = 0;
    end else begin
      if (sb.size() != 0 && out_ready) begin
        log_q.push_back({out_src, out_data});
        logc.push_back(cyc);
        void'(sb.pop_front());
      end
      if (g >= 0 && er[g] && in_valid[g]) begin
        sb.push_back({2'(g), src_q[g][0].l, src_q[g][0].d});
        acc = g;
        if (src_q[g][0].l) begin
          m_lock = 0;
          m_ptr = (g + 1) % N;
        end else begin
          m_lock = 1;
          m_lid = g;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc >= 0) void'(src_q[acc].pop_front());
  endtask

  task automatic run_until_idle(string tag);
    int n = 0;
    en = '1;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() +
            src_q[3].size() + sb.size()) != 0 && n < 200) begin
      drive();
      tick();
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL %s timeout cycles=%0d limit=200", tag, n);
    end
  endtask

  initial begin
    int len;
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = '0;
    in_data = '0;
    in_last = '0;
    en = '1;

    // reset with all requesters valid; queues double as the RR stimulus
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 2; r++)
        src_q[i].push_back({32'hA0 + 32'(i), 1'b1});
    drive();
    @(posedge clk);
    #1;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;

    drive();
    #1;
    chk("first_grant", 64'(in_ready), 64'b0001);
    for (int k = 0; k < 8; k++) begin
      drive();
      tick();
      chk("rr_src", 64'(out_src), 64'(k % 4));
      chk("rr_data", 64'(out_data), 64'(32'hA0 + 32'(k % 4)));
      chk("rr_valid", 64'(out_valid), 64'd1);
    end
    run_until_idle("rr_drain");

    // move pointer to 1, then packet lock
    src_q[0].push_back({32'h1, 1'b1});
    run_until_idle("lock_pre");
    log_q.delete();
    logc.delete();
    src_q[0].push_back({32'h0A, 1'b1});
    src_q[1].push_back({32'h11, 1'b0});
    src_q[1].push_back({32'h12, 1'b0});
    src_q[1].push_back({32'h13, 1'b1});
    src_q[2].push_back({32'h21, 1'b1});
    run_until_idle("lock");
    chk("lock_n", 64'(log_q.size()), 64'd5);
    chk("lock_b0", 64'(lg(0)), {30'd0, 2'd1, 32'h11});
    chk("lock_b1", 64'(lg(1)), {30'd0, 2'd1, 32'h12});
    chk("lock_b2", 64'(lg(2)), {30'd0, 2'd1, 32'h13});
    chk("lock_b3", 64'(lg(3)), {30'd0, 2'd2, 32'h21});
    chk("lock_b4", 64'(lg(4)), {30'd0, 2'd0, 32'h0A});
    if (logc.size() == 5)
      chk("lock_contig", 64'(logc[4] - logc[0]), 64'd4);

    // bubble inside a locked packet
    log_q.delete();
    logc.delete();
    src_q[3].push_back({32'h31, 1'b0});
    src_q[3].push_back({32'h32, 1'b1});
    src_q[0].push_back({32'h0B, 1'b1});
    drive();
    tick();
    en[3] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive();
      tick();
      chk("bubble_ready", 64'(in_ready), 64'b1000);
    end
    run_until_idle("bubble");
    chk("bubble_n", 64'(log_q.size()), 64'd3);
    chk("bubble_b0", 64'(lg(0)), {30'd0, 2'd3, 32'h31});
    chk("bubble_b1", 64'(lg(1)), {30'd0, 2'd3, 32'h32});
    chk("bubble_b2", 64'(lg(2)), {30'd0, 2'd0, 32'h0B});

    // backpressure
    log_q.delete();
    logc.delete();
    src_q[1].push_back({32'hDEADBEEF, 1'b1});
    src_q[2].push_back({32'h22222222, 1'b1});
    drive();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive();
      tick();
      chk("bp_data", 64'(out_data), 64'hDEADBEEF);
      chk("bp_src", 64'(out_src), 64'd1);
      chk("bp_last", 64'(out_last), 64'd1);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    run_until_idle("bp");
    chk("bp_n", 64'(log_q.size()), 64'd2);
    chk("bp_b0", 64'(lg(0)), {30'd0, 2'd1, 32'hDEADBEEF});
    chk("bp_b1", 64'(lg(1)), {30'd0, 2'd2, 32'h22222222});
    if (logc.size() == 2)
      chk("bp_contig", 64'(logc[1] - logc[0]), 64'd1);

    // reset mid-packet drops the held beat and clears lock
    log_q.delete();
    logc.delete();
    src_q[2].push_back({32'h41, 1'b0});
    src_q[2].push_back({32'h42, 1'b0});
    src_q[2].push_back({32'h43, 1'b1});
    drive();
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    src_q[2].delete();
    src_q[2].push_back({32'h44, 1'b1});
    src_q[0].push_back({32'h0C, 1'b1});
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    drive();
    #1;
    chk("mid_rst_grant", 64'(in_ready), 64'b0001);
    run_until_idle("mid_rst");
    chk("mid_rst_n", 64'(log_q.size()), 64'd2);
    chk("mid_rst_b0", 64'(lg(0)), {30'd0, 2'd0, 32'h0C});
    chk("mid_rst_b1", 64'(lg(1)), {30'd0, 2'd2, 32'h44});

    // random traffic with legal bubbles and backpressure
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(1, 0) == 1) begin
          len = $urandom_range(4, 1);
          for (int j = 0; j < len; j++)
            src_q[i].push_back({32'($urandom()), j == len - 1});
        end
        if (!in_valid[i] || acc == i)
          en[i] = $urandom_range(2, 0) != 0;
      end
      out_ready = $urandom_range(3, 0) != 0;
      drive();
      tick();
    end
    out_ready = 1'b1;
    run_until_idle("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares one ready/valid pipeline stage among N_REQ independent requesters. Each requester presents a packet stream (data plus last flag); the arbiter grants one requester at a time, holds the grant for the whole packet, and forwards accepted beats through a single registered output stage tagged with the source index. It sits in front of the shared datapath stage and owns its input handshake.

## Interface
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 32, beat width in bits
- SRC_W, derived = clog2(N_REQ) (minimum 1), width of source tag; not overridden

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  N_REQ  per-requester valid
- in_ready  out  N_REQ  per-requester ready
- in_data  in  N_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- in_last  in  N_REQ  per-requester last-beat-of-packet flag
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_data  out  DATA_W  output beat
- out_last  out  1  last beat of packet
- out_src  out  SRC_W  index of requester that sent the beat

## Operation
- State: rr_ptr (SRC_W), lock (1), lock_id (SRC_W), output register {out_valid, out_data, out_last, out_src}.
- Reset: out_valid=0, out_data=0, out_last=0, out_src=0, rr_ptr=0, lock=0, lock_id=0; in_ready all 0 during reset cycle.
- Stage can load: load_en = !out_valid || out_ready.
- Grant (combinational):
  - lock=1: grant = lock_id, regardless of other in_valid.
  - lock=0: grant = first i with in_valid[i]=1 searching rr_ptr, rr_ptr+1, ... wrapping mod N_REQ; no grant if all in_valid=0.
- in_ready[i] = (i == grant) && grant exists/locked && load_en && !rst; all other bits 0.
- Beat accepted when in_valid[g] && in_ready[g]: output register loads in_data[g], in_last[g], out_src=g, out_valid=1.
- Lock update on accepted beat: in_last=0 -> lock=1, lock_id=g; in_last=1 -> lock=0, rr_ptr=(g+1) mod N_REQ (wrap from N_REQ-1 to 0).
- Single-beat packet (in_last=1 on first beat): no lock, pointer advances immediately.
- Locked with in_valid[lock_id]=0 (bubble): no transfer, lock held, other requesters wait.
- Output register: if out_valid && out_ready and no new beat accepted, out_valid<=0; with out_ready=0, out_valid/out_data/out_last/out_src hold unchanged.
- Requesters must hold in_valid/in_data/in_last stable until accepted; the arbiter does not re-evaluate a locked grant.
- rst asserted mid-packet: lock cleared, rr_ptr=0, any held output beat dropped; the partial packet is not completed by the arbiter.

## Timing
- Latency: beat accepted at edge N appears on out_* after edge N (valid in cycle N+1).
- Throughput: one beat per cycle when out_ready=1 continuously, including back-to-back packets from different requesters (no idle cycle at packet boundary).
- in_ready is combinational from in_valid, rr_ptr, lock and out_ready; no combinational path from in_data to any output.
- Under backpressure with out_valid=1 and out_ready=0: in_ready all 0, output held.
- Fairness: any continuously requesting requester is granted within N_REQ-1 packets of others.

## Test plan
- Reset: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_src=0, in_ready=0000; after release first grant goes to requester 0.
- Round-robin: all 4 requesters send single-beat packets 0xA0..0xA3 continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,... one beat per cycle, data matches source.
- Packet lock: req1 sends 3-beat packet 0x11,0x12,0x13(last) while req0/req2 valid -> output 0x11,0x12,0x13 all out_src=1 contiguous, next grant req2, then req0.
- Bubble in locked packet: req3 drops in_valid for 2 cycles after first beat of 2-beat packet, req0 valid -> no req0 beat appears until req3 last beat 0x32 accepted.
- Backpressure: out_ready=0 for 4 cycles holding 0xDEADBEEF -> out_data/out_src/out_last stable, in_ready=0; out_ready=1 -> beat consumed, next beat loads same edge, no loss or duplication.
- Reset mid-packet: rst=1 after first beat of req2 3-beat packet -> out_valid=0, lock cleared; after release with req0 and req2 valid, grant goes to req0 (rr_ptr=0).
